regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Owns the single write port of the 32x32 register file and shares it between two writers: the pipeline writeback stage and the multi-cycle multdiv unit. It buffers one multdiv result, forces it through if it waits too long, and routes multdiv exceptions to the status register. It also keeps a busy scoreboard of multdiv destinations, so decode stalls on RAW/WAW hazards. It sits between the W stage, the multdiv unit and the regfile write inputs.

Parameters:
MAX_WAIT, 4, cycles a buffered multdiv result may lose arbitration before the pipeline is stalled
STATUS_REG, 30, register written on multdiv exception
EXC_CODE, 32'd4, value written to STATUS_REG on multdiv exception

Ports:
clock  in  1  single clock, rising edge
ctrl_reset_n  in  1  asynchronous, active-low reset
pipe_we  in  1  W-stage write request
pipe_rd  in  5  W-stage destination
pipe_data  in  32  W-stage write data
pipe_stall  out  1  W stage must hold its outputs this cycle
md_issue  in  1  multdiv op issued this cycle
md_issue_rd  in  5  destination of issued op
md_valid  in  1  multdiv result available
md_ready  out  1  result accepted when md_valid && md_ready
md_rd  in  5  result destination
md_data  in  32  result value
md_exception  in  1  result is an exception (div by zero / overflow)
dec_rs1, dec_rs2, dec_rd  in  5 each  decode-stage register numbers
dec_use  in  3  valid bits for {rd, rs2, rs1}
hazard_stall  out  1  decode must stall
ctrl_writeEnable  out  1  to regfile
ctrl_writeReg  out  5  to regfile
data_writeReg  out  32  to regfile

Behaviour:
- Reset (async, ctrl_reset_n=0): buffer empty, busy[31:0]=0, wait counter=0, state IDLE. Outputs: pipe_stall=0, md_ready=1, hazard_stall=0, ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0. If reset arrives mid-operation, any buffered result is discarded. No regfile write occurs.
- Buffer: one entry holds {rd, data, exc}. md_ready = buffer empty. A result is captured on the edge where md_valid && md_ready.
- Exception rewrite at capture: if md_exception, the entry gets rd_w=STATUS_REG and data=EXC_CODE. The original md_rd is kept separately so its busy bit can be cleared.
- Write port mux (combinational, same cycle):
  - Pipe wins if pipe_we=1 and state is not FORCE. The write is pipe_rd/pipe_data.
  - Otherwise, if the buffer is full, the buffer is written and drained on that edge.
  - Otherwise, ctrl_writeEnable=0.
  - Any write to r0 is suppressed: ctrl_writeEnable=0. A buffer targeting r0 still drains.
- There is no direct md-to-regfile bypass. Minimum latency is 1 cycle from acceptance to write.
- State machine:
  - IDLE: buffer empty. Capture moves to HOLD with wait=0.
  - HOLD: if the buffer drains, go to IDLE, or stay in HOLD if a new result is captured on the same edge (wait=0). If it loses to the pipe, wait++. When wait reaches MAX_WAIT-1 and it loses again, go to FORCE.
  - FORCE: pipe_stall=1 combinationally. The buffer writes this cycle, then the state goes to IDLE (or HOLD on a simultaneous capture). The pipe write is retried next cycle. The pipeline must hold pipe_we/rd/data while pipe_stall=1.
- Scoreboard:
  - md_issue with md_issue_rd!=0 sets busy[md_issue_rd].
  - A buffer drain clears busy of the original md_rd. This includes exceptions.
  - Set and clear on the same register in the same cycle: set wins.
  - busy[0] stays 0.
- hazard_stall (combinational) = OR over the valid dec_* fields of busy[field]. It also asserts when dec_use[2] and the pipe is writing STATUS_REG while busy[STATUS_REG] is set. A register is not considered ready until the cycle after its drain edge; there is no forwarding.
- The regfile write-port outputs are combinational from registered state and the pipe_* inputs. Nothing else has a combinational path to them.

Decomposition:
- Shared package: MAX_WAIT default, STATUS_REG, EXC_CODE, and state encodings IDLE=2'd0, HOLD=2'd1, FORCE=2'd2.
- One natural sub-module: regfile_busy_scoreboard. It holds the 32-bit busy vector with set/clear ports and three lookup outputs.

Test Plan:
- Reset then idle: drop ctrl_reset_n mid-HOLD with the buffer full -> all outputs at reset values next sample, md_ready=1, busy=0, no write after release.
- Idle-port drain: md_valid, md_rd=5, md_data=32'h1234, pipe_we=0 -> accepted at edge N; ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=32'h1234 during cycle N+1; busy[5] cleared at edge N+1.
- Starvation: buffer full with rd=7, pipe_we=1 every cycle with rd=3 -> the pipe wins 4 cycles; 5th cycle pipe_stall=1 and r7 written; next cycle r3 written with the held pipe data.
- Exception: md_exception=1, md_rd=9 -> the write goes to r30 with data 32'd4; r9 is not written; busy[9] clears.
- Hazard: md_issue rd=12; next cycle dec_rs2=12, dec_use=3'b010 -> hazard_stall=1 until the cycle after r12's drain, then 0. The same check with dec_rd=12, dec_use=3'b100 -> stall.
- r0 / same-cycle set/clear: md result to r0 -> no regfile write and the buffer empties. Issue rd=4 on the same edge rd=4 drains -> busy[4] remains 1.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants, state encoding and buffer entry layout for the regfile write arbiter.
package regfile_write_arbiter_pkg;

  localparam int unsigned REG_AW       = 5;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned MAX_WAIT_DEF = 4;

  localparam logic [REG_AW-1:0] STATUS_REG = 5'd30;
  localparam logic [DATA_W-1:0] EXC_CODE   = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FORCE = 2'd2
  } arb_state_t;

  // rd_w is the register actually written; rd_orig is the scoreboard entry to release.
  typedef struct packed {
    logic [REG_AW-1:0] rd_w;
    logic [REG_AW-1:0] rd_orig;
    logic [DATA_W-1:0] data;
  } md_entry_t;

endpackage

// File: rtl/regfile_busy_scoreboard.sv
// Busy bits for registers awaiting a multdiv result; set wins over clear, r0 never busy.
module regfile_busy_scoreboard
  import regfile_write_arbiter_pkg::*;
(
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_rd,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_rd,
  input  logic [REG_AW-1:0] rd_a,
  input  logic [REG_AW-1:0] rd_b,
  input  logic [REG_AW-1:0] rd_c,
  output logic              busy_a,
  output logic              busy_b,
  output logic              busy_c,
  output logic              status_busy
);

  logic [31:0] busy_q;
  logic [31:0] busy_nxt;

  always_comb begin
    busy_nxt = busy_q;
    if (clr_en) busy_nxt[clr_rd] = 1'b0;
    if (set_en) busy_nxt[set_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) busy_q <= '0;
    else               busy_q <= busy_nxt;
  end

  assign busy_a      = busy_q[rd_a];
  assign busy_b      = busy_q[rd_b];
  assign busy_c      = busy_q[rd_c];
  assign status_busy = busy_q[STATUS_REG];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between the W stage and a one-entry multdiv result buffer,
// forcing the buffer through after MAX_WAIT lost arbitrations and tracking multdiv hazards.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              pipe_we,
  input  logic [REG_AW-1:0] pipe_rd,
  input  logic [DATA_W-1:0] pipe_data,
  output logic              pipe_stall,
  input  logic              md_issue,
  input  logic [REG_AW-1:0] md_issue_rd,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [REG_AW-1:0] md_rd,
  input  logic [DATA_W-1:0] md_data,
  input  logic              md_exception,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic [2:0]        dec_use,
  output logic              hazard_stall,
  output logic              ctrl_writeEnable,
  output logic [REG_AW-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg
);

  localparam int unsigned WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  arb_state_t    state_q, state_nxt;
  logic [WW-1:0] wait_q, wait_nxt;
  md_entry_t     entry_q, entry_nxt;

  logic buf_full, pipe_wins, drain, capture;
  logic busy_a, busy_b, busy_c, status_busy;

  assign buf_full   = (state_q != IDLE);
  assign pipe_wins  = pipe_we && (state_q != FORCE);
  assign drain      = buf_full && !pipe_wins;
  assign md_ready   = !buf_full;
  assign capture    = md_valid && md_ready;
  assign pipe_stall = (state_q == FORCE);

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      entry_q <= '0;
    end else begin
      state_q <= state_nxt;
      wait_q  <= wait_nxt;
      entry_q <= entry_nxt;
    end
  end

  // Next state, starvation counter and buffer capture with exception rewrite.
  always_comb begin
    state_nxt = state_q;
    wait_nxt  = wait_q;
    entry_nxt = entry_q;
    if (capture) begin
      entry_nxt.rd_w    = md_exception ? STATUS_REG : md_rd;
      entry_nxt.rd_orig = md_rd;
      entry_nxt.data    = md_exception ? EXC_CODE : md_data;
      state_nxt         = HOLD;
      wait_nxt          = '0;
    end else if (drain) begin
      state_nxt = IDLE;
      wait_nxt  = '0;
    end else if ((state_q == HOLD) && pipe_wins) begin
      if (wait_q == WW'(MAX_WAIT - 1)) state_nxt = FORCE;
      else                             wait_nxt  = wait_q + 1'b1;
    end
  end

  // Write port mux; r0 targets still select (and drain) but never enable.
  always_comb begin
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
    if (pipe_wins) begin
      ctrl_writeReg    = pipe_rd;
      data_writeReg    = pipe_data;
      ctrl_writeEnable = (pipe_rd != '0);
    end else if (buf_full) begin
      ctrl_writeReg    = entry_q.rd_w;
      data_writeReg    = entry_q.data;
      ctrl_writeEnable = (entry_q.rd_w != '0);
    end
  end

  regfile_busy_scoreboard u_scoreboard (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .set_en       (md_issue && (md_issue_rd != '0)),
    .set_rd       (md_issue_rd),
    .clr_en       (drain),
    .clr_rd       (entry_q.rd_orig),
    .rd_a         (dec_rs1),
    .rd_b         (dec_rs2),
    .rd_c         (dec_rd),
    .busy_a       (busy_a),
    .busy_b       (busy_b),
    .busy_c       (busy_c),
    .status_busy  (status_busy)
  );

  // A pending exception will overwrite STATUS_REG, so a pipe write to it cannot be trusted yet.
  assign hazard_stall = (dec_use[0] && busy_a) || (dec_use[1] && busy_b) ||
                        (dec_use[2] && busy_c) ||
                        (dec_use[2] && pipe_wins && (pipe_rd == STATUS_REG) && status_busy);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_exception;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [2:0]  dec_use;
  logic        hazard_stall;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  regfile_write_arbiter dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .pipe_we          (pipe_we),
    .pipe_rd          (pipe_rd),
    .pipe_data        (pipe_data),
    .pipe_stall       (pipe_stall),
    .md_issue         (md_issue),
    .md_issue_rd      (md_issue_rd),
    .md_valid         (md_valid),
    .md_ready         (md_ready),
    .md_rd            (md_rd),
    .md_data          (md_data),
    .md_exception     (md_exception),
    .dec_rs1          (dec_rs1),
    .dec_rs2          (dec_rs2),
    .dec_rd           (dec_rd),
    .dec_use          (dec_use),
    .hazard_stall     (hazard_stall),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge; outputs are checked on the falling edge.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic check_port(input string tag, input logic we, input logic [4:0] rd,
                            input logic [31:0] data);
    check({tag, ".we"}, 32'(ctrl_writeEnable), 32'(we));
    if (we) begin
      check({tag, ".reg"}, 32'(ctrl_writeReg), 32'(rd));
      check({tag, ".data"}, data_writeReg, data);
    end
  endtask

  task automatic idle_inputs();
    pipe_we = 0; pipe_rd = 0; pipe_data = 0;
    md_issue = 0; md_issue_rd = 0;
    md_valid = 0; md_rd = 0; md_data = 0; md_exception = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_use = 0;
  endtask

  initial begin
    idle_inputs();
    ctrl_reset_n = 0;
    next_cycle();
    next_cycle();
    settle();
    check("rst.stall", 32'(pipe_stall), 0);
    check("rst.ready", 32'(md_ready), 1);
    check("rst.hazard", 32'(hazard_stall), 0);
    check("rst.we", 32'(ctrl_writeEnable), 0);
    check("rst.reg", 32'(ctrl_writeReg), 0);
    check("rst.data", data_writeReg, 0);
    next_cycle();
    ctrl_reset_n = 1;

    // Idle-port drain of r5
    next_cycle();
    md_issue = 1; md_issue_rd = 5;
    next_cycle();
    md_issue = 0;
    md_valid = 1; md_rd = 5; md_data = 32'h1234;
    dec_rs1 = 5; dec_use = 3'b001;
    settle();
    check("drain.ready_before", 32'(md_ready), 1);
    check("drain.hazard_busy", 32'(hazard_stall), 1);
    check("drain.no_bypass", 32'(ctrl_writeEnable), 0);
    next_cycle();
    md_valid = 0;
    settle();
    check_port("drain.write", 1, 5, 32'h1234);
    check("drain.ready_full", 32'(md_ready), 0);
    check("drain.hazard_drain_cycle", 32'(hazard_stall), 1);
    next_cycle();
    settle();
    check("drain.we_after", 32'(ctrl_writeEnable), 0);
    check("drain.hazard_cleared", 32'(hazard_stall), 0);
    check("drain.ready_after", 32'(md_ready), 1);
    dec_use = 0;

    // Starvation: r7 buffered while the pipe writes r3 every cycle
    next_cycle();
    md_valid = 1; md_rd = 7; md_data = 32'h77;
    next_cycle();
    md_valid = 0;
    pipe_we = 1; pipe_rd = 3; pipe_data = 32'h33;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("starve.pipe%0d", i), 32'(pipe_stall), 0);
      check_port($sformatf("starve.pipe%0d", i), 1, 3, 32'h33);
      next_cycle();
    end
    settle();
    check("starve.force_stall", 32'(pipe_stall), 1);
    check_port("starve.force", 1, 7, 32'h77);
    next_cycle();
    settle();
    check("starve.retry_stall", 32'(pipe_stall), 0);
    check_port("starve.retry", 1, 3, 32'h33);
    check("starve.ready", 32'(md_ready), 1);
    next_cycle();
    pipe_we = 0; pipe_rd = 0; pipe_data = 0;

    // Exception from an op targeting r9
    md_issue = 1; md_issue_rd = 9;
    next_cycle();
    md_issue = 0;
    md_valid = 1; md_rd = 9; md_data = 32'hdead_beef; md_exception = 1;
    dec_rs1 = 9; dec_use = 3'b001;
    next_cycle();
    md_valid = 0; md_exception = 0;
    settle();
    check_port("exc.write", 1, 30, 32'd4);
    check("exc.hazard_drain_cycle", 32'(hazard_stall), 1);
    next_cycle();
    settle();
    check("exc.busy9_cleared", 32'(hazard_stall), 0);
    check("exc.we_after", 32'(ctrl_writeEnable), 0);
    dec_use = 0;

    // RAW on rs2 and WAW on rd against r12
    next_cycle();
    md_issue = 1; md_issue_rd = 12;
    next_cycle();
    md_issue = 0;
    dec_rs2 = 12; dec_use = 3'b010;
    settle();
    check("haz.rs2", 32'(hazard_stall), 1);
    next_cycle();
    dec_rs2 = 0; dec_rd = 12; dec_use = 3'b100;
    settle();
    check("haz.rd", 32'(hazard_stall), 1);
    dec_rs1 = 12; dec_use = 3'b010;
    #1;
    check("haz.unused_field", 32'(hazard_stall), 0);
    dec_use = 3'b100;
    next_cycle();
    md_valid = 1; md_rd = 12; md_data = 32'hc;
    next_cycle();
    md_valid = 0;
    settle();
    check("haz.drain_cycle", 32'(hazard_stall), 1);
    next_cycle();
    settle();
    check("haz.after_drain", 32'(hazard_stall), 0);
    dec_use = 0;

    // Result to r0 drains without a write
    next_cycle();
    md_valid = 1; md_rd = 0; md_data = 32'h55;
    next_cycle();
    md_valid = 0;
    settle();
    check("r0.we", 32'(ctrl_writeEnable), 0);
    check("r0.ready_full", 32'(md_ready), 0);
    next_cycle();
    settle();
    check("r0.ready_drained", 32'(md_ready), 1);

    // Set and clear of r4 on the same edge: set wins
    next_cycle();
    md_issue = 1; md_issue_rd = 4;
    next_cycle();
    md_issue = 0;
    md_valid = 1; md_rd = 4; md_data = 32'h4;
    next_cycle();
    md_valid = 0;
    md_issue = 1; md_issue_rd = 4;
    settle();
    check_port("sc.write", 1, 4, 32'h4);
    next_cycle();
    md_issue = 0;
    dec_rs1 = 4; dec_use = 3'b001;
    settle();
    check("sc.set_wins", 32'(hazard_stall), 1);
    md_valid = 1; md_rd = 4; md_data = 32'h44;
    next_cycle();
    md_valid = 0;
    next_cycle();
    settle();
    check("sc.cleared", 32'(hazard_stall), 0);
    dec_use = 0;

    // Pipe write to STATUS_REG while r30 is owned by multdiv
    next_cycle();
    md_issue = 1; md_issue_rd = 30;
    next_cycle();
    md_issue = 0;
    pipe_we = 1; pipe_rd = 30; pipe_data = 32'h1;
    dec_rd = 1; dec_use = 3'b100;
    settle();
    check("status.pipe_hazard", 32'(hazard_stall), 1);
    pipe_rd = 29;
    #1;
    check("status.other_rd", 32'(hazard_stall), 0);
    next_cycle();
    pipe_we = 0; pipe_rd = 0; dec_use = 0;
    md_valid = 1; md_rd = 30; md_data = 32'h30;
    next_cycle();
    md_valid = 0;
    next_cycle();

    // Reset in the middle of HOLD with r20 buffered
    md_issue = 1; md_issue_rd = 20;
    next_cycle();
    md_issue = 0;
    md_valid = 1; md_rd = 20; md_data = 32'h20;
    next_cycle();
    md_valid = 0;
    pipe_we = 1; pipe_rd = 3; pipe_data = 32'h33;
    settle();
    check("mrst.hold_ready", 32'(md_ready), 0);
    next_cycle();
    pipe_we = 0; pipe_rd = 0; pipe_data = 0;
    dec_rs1 = 20; dec_use = 3'b001;
    ctrl_reset_n = 0;
    settle();
    check("mrst.ready", 32'(md_ready), 1);
    check("mrst.we", 32'(ctrl_writeEnable), 0);
    check("mrst.stall", 32'(pipe_stall), 0);
    check("mrst.hazard", 32'(hazard_stall), 0);
    next_cycle();
    ctrl_reset_n = 1;
    next_cycle();
    settle();
    check("mrst.no_write", 32'(ctrl_writeEnable), 0);
    check("mrst.ready_after", 32'(md_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
